// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared FSM state type, glyph table and input word bit positions for the hex display scanner.
package hex_disp_pkg;

    typedef enum logic [1:0] {LOAD, SHOW, BLANK} disp_state_e;

    localparam int RAW_BIT = 7;
    localparam int DP_BIT = 8;

    // Active-high {g,f,e,d,c,b,a}; index 15 is leftmost in the concatenation.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_display_scanner_decoder.sv
// hex7seg_decoder: combinational 4-bit to active-high 7-segment lookup.
module hex7seg_decoder (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    import hex_disp_pkg::*;

    assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: snapshots eight hex registers per frame and scans them onto a shared 7-segment bus.
// Optional leading-zero blanking when HEX_LZ_BLANK_EN is defined.
module hex_display_scanner #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIGIT_HZ = 8_000,
    parameter int BLANK_CYC = 16,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] io_hex0_i,
    input  logic [31:0] io_hex1_i,
    input  logic [31:0] io_hex2_i,
    input  logic [31:0] io_hex3_i,
    input  logic [31:0] io_hex4_i,
    input  logic [31:0] io_hex5_i,
    input  logic [31:0] io_hex6_i,
    input  logic [31:0] io_hex7_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);
    import hex_disp_pkg::*;

    localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;
    localparam int MAXC = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
    localparam int CW = $clog2(MAXC);
    localparam logic POL = (SEG_ACTIVE_LOW != 0);

    if (TICK_DIV < 2 || BLANK_CYC < 1) begin : g_param_check
        $error("hex_display_scanner: TICK_DIV must be >= 2 and BLANK_CYC >= 1");
    end

    disp_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] digit, digit_n;
    logic [31:0] hex_in [8];
    logic [8:0] shadow [8];
    logic [8:0] cur;
    logic [6:0] glyph, seg_h;
    logic [7:0] an_h, lz_mask;
    logic dp_h, frame_n, load;
    logic unused_hi;

    assign hex_in = '{io_hex0_i, io_hex1_i, io_hex2_i, io_hex3_i,
                      io_hex4_i, io_hex5_i, io_hex6_i, io_hex7_i};
    assign unused_hi = ^{io_hex0_i[31:9], io_hex1_i[31:9], io_hex2_i[31:9], io_hex3_i[31:9],
                         io_hex4_i[31:9], io_hex5_i[31:9], io_hex6_i[31:9], io_hex7_i[31:9]};
    assign cur = shadow[digit];

    hex7seg_decoder u_dec (
        .nib(cur[3:0]),
        .seg(glyph)
    );

`ifdef HEX_LZ_BLANK_EN
    logic [7:0] lz_next;
    logic lz_run;
    // A digit blanks only while every digit to its left is a blanked hex zero.
    always_comb begin
        lz_next = '0;
        lz_run = 1'b1;
        for (int n = 7; n >= 1; n--) begin
            lz_next[n] = lz_run && !hex_in[n][RAW_BIT] && hex_in[n][3:0] == 4'h0;
            lz_run = lz_next[n];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) lz_mask <= '0;
        else if (load) lz_mask <= lz_next;
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        digit_n = digit;
        load = 1'b0;
        frame_n = 1'b0;
        an_h = '0;
        seg_h = '0;
        dp_h = 1'b0;
        if (!en_i) begin
            state_n = LOAD;
            cnt_n = '0;
            digit_n = '0;
        end else begin
            case (state)
                LOAD: begin
                    load = 1'b1;
                    frame_n = 1'b1;
                    cnt_n = '0;
                    digit_n = '0;
                    state_n = SHOW;
                end
                SHOW: begin
                    an_h = lz_mask[digit] ? 8'h00 : 8'h01 << digit;
                    seg_h = lz_mask[digit] ? 7'h00 : (cur[RAW_BIT] ? cur[6:0] : glyph);
                    dp_h = !lz_mask[digit] && cur[DP_BIT];
                    if (cnt == CW'(TICK_DIV - 1)) begin
                        state_n = BLANK;
                        cnt_n = '0;
                    end
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_CYC - 1)) begin
                        cnt_n = '0;
                        state_n = (digit == 3'd7) ? LOAD : SHOW;
                        digit_n = digit + 3'd1;
                    end
                end
                default: state_n = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state <= LOAD;
            cnt <= '0;
            digit <= '0;
            frame_o <= 1'b0;
            an_o <= {8{POL}};
            seg_o <= {7{POL}};
            dp_o <= POL;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            digit <= digit_n;
            frame_o <= frame_n;
            an_o <= an_h ^ {8{POL}};
            seg_o <= seg_h ^ {7{POL}};
            dp_o <= dp_h ^ POL;
        end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 8; i++) shadow[i] <= hex_in[i][8:0];
        end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed scoreboard bench for hex_display_scanner (TICK_DIV=4, BLANK_CYC=2, active-low).
module tb_hex_display_scanner;

    typedef struct packed {
        logic       fr;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       cs;
    } exp_t;

    localparam exp_t OFF = '{fr: 1'b0, an: 8'hFF, seg: 7'h7F, dp: 1'b1, cs: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic [31:0] hv [8];
    logic [6:0] seg;
    logic dp, frame;
    logic [7:0] an;
    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    exp_t q [$];
    int n_chk = 0;
    int n_fail = 0;

    hex_display_scanner #(
        .CLK_HZ(1000),
        .DIGIT_HZ(250),
        .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .io_hex0_i(hv[0]),
        .io_hex1_i(hv[1]),
        .io_hex2_i(hv[2]),
        .io_hex3_i(hv[3]),
        .io_hex4_i(hv[4]),
        .io_hex5_i(hv[5]),
        .io_hex6_i(hv[6]),
        .io_hex7_i(hv[7]),
        .seg_o(seg),
        .dp_o(dp),
        .an_o(an),
        .frame_o(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one full frame of expected outputs from the register values at snapshot time.
    task automatic push_frame();
        exp_t e;
        logic [31:0] w;
        logic [7:0] lz;
        lz = '0;
`ifdef HEX_LZ_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int n = 7; n >= 1; n--) begin
                lz[n] = lead && !hv[n][7] && hv[n][3:0] == 4'h0;
                lead = lz[n];
            end
        end
`endif
        e = OFF;
        e.fr = 1'b1;
        q.push_back(e);
        for (int d = 0; d < 8; d++) begin
            w = hv[d];
            e.fr = 1'b0;
            e.an = lz[d] ? 8'hFF : ~(8'h01 << d);
            e.seg = ~(w[7] ? w[6:0] : gl[w[3:0]]);
            e.dp = ~w[8];
            e.cs = !lz[d];
            repeat (4) q.push_back(e);
            repeat (2) q.push_back(OFF);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                e = q.pop_front();
                chk("frame_o", frame, e.fr);
                chk("an_o", an, e.an);
                if (e.cs) begin
                    chk("seg_o", seg, e.seg);
                    chk("dp_o", dp, e.dp);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hv[i] = 32'h0;
        hv[0] = 32'h3;
        repeat (3) q.push_back(OFF);
        step(3);
        rst = 1'b0;
        push_frame();
        step(49);
        push_frame();
        step(49);

        hv[5] = 32'h1AA;
        push_frame();
        step(49);

        hv[2] = 32'h1;
        push_frame();
        step(8);
        hv[2] = 32'hF;
        step(41);
        push_frame();
        step(49);

        push_frame();
        step(27);
        en = 1'b0;
        q.delete();
        repeat (10) q.push_back(OFF);
        step(10);
        en = 1'b1;
        push_frame();
        step(49);

        push_frame();
        step(3);
        #1 rst = 1'b1;
        #1;
        chk("async_an", an, 8'hFF);
        chk("async_seg", seg, 7'h7F);
        chk("async_dp", dp, 1'b1);
        chk("async_frame", frame, 1'b0);
        q.delete();
        q.push_back(OFF);
        step(1);
        rst = 1'b0;
        push_frame();
        step(49);

        for (int i = 0; i < 8; i++) hv[i] = 32'h0;
        hv[0] = 32'h5;
        hv[2] = 32'h7;
        push_frame();
        step(49);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
